// File: rtl/ula_8_bits_if.sv
// Operand/result bundle for the 8-bit ALU. The optional Z flag exists only
// when ULA_ZERO_FLAG_EN is defined.
interface ula_8_bits_if #(parameter int WIDTH = 8);
    logic             CIN;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       X;
    logic [WIDTH-1:0] S;
    logic             COUT;
`ifdef ULA_ZERO_FLAG_EN
    logic             Z;
`endif

    modport master (
        output CIN, A, B, X,
`ifdef ULA_ZERO_FLAG_EN
        input  Z,
`endif
        input  S, COUT
    );

    modport slave (
        input  CIN, A, B, X,
`ifdef ULA_ZERO_FLAG_EN
        output Z,
`endif
        output S, COUT
    );
endinterface

// File: rtl/ula_8_bits.sv
// 8-bit ALU: ripple full-adder / full-subtractor chains plus AND/OR/NOT, one
// cycle latency. Define ULA_ZERO_FLAG_EN to add the registered zero flag Z.
module ula_8_bits #(
    parameter int WIDTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    ula_8_bits_if.slave bus
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100
    } op_e;

    logic [WIDTH:0]   carry;
    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;

    // CIN doubles as carry-in for the adder and borrow-in for the subtractor.
    assign carry[0]  = bus.CIN;
    assign borrow[0] = bus.CIN;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        assign sum[i]      = bus.A[i] ^ bus.B[i] ^ carry[i];
        assign carry[i+1]  = (bus.A[i] & bus.B[i]) | (carry[i] & (bus.A[i] ^ bus.B[i]));
        assign diff[i]     = bus.A[i] ^ bus.B[i] ^ borrow[i];
        assign borrow[i+1] = (~bus.A[i] & bus.B[i]) | (~(bus.A[i] ^ bus.B[i]) & borrow[i]);
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        s_d    = '0;
        cout_d = 1'b0;
        case (op_e'(bus.X))
            OP_ADD: begin
                s_d    = sum;
                cout_d = carry[WIDTH];
            end
            OP_SUB: begin
                s_d    = diff;
                cout_d = borrow[WIDTH];
            end
            OP_AND:  s_d = bus.A & bus.B;
            OP_OR:   s_d = bus.A | bus.B;
            OP_NOT:  s_d = ~bus.A;
            default: s_d = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign bus.S    = s_q;
    assign bus.COUT = cout_q;

`ifdef ULA_ZERO_FLAG_EN
    logic z_q;

    // Z tracks the reset value of S, so it comes out of reset set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) z_q <= 1'b1;
        else     z_q <= (s_d == '0);
    end

    assign bus.Z = z_q;
`endif

endmodule

// File: tb/tb_ula_8_bits.sv
// Scoreboard bench for ula_8_bits: expectations are queued when operands are
// driven and compared one clock later, plus async-reset and hold checks.
module tb_ula_8_bits;

    typedef struct packed {
        logic [7:0] s;
        logic       cout;
        logic       z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    ula_8_bits_if #(.WIDTH(8)) bus ();

    ula_8_bits dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic [2:0] x);
        exp_t       e;
        logic [8:0] wide;
        e = '0;
        case (x)
            3'b000: begin
                wide   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
                e.s    = wide[7:0];
                e.cout = wide[8];
            end
            3'b001: begin
                wide   = {1'b0, a} - {1'b0, b} - {8'd0, cin};
                e.s    = wide[7:0];
                e.cout = wide[8];
            end
            3'b010:  e.s = a & b;
            3'b011:  e.s = a | b;
            3'b100:  e.s = ~a;
            default: e.s = 8'h00;
        endcase
        e.z = (e.s == 8'h00);
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".S"}, 32'(bus.S), 32'(e.s));
        check({tag, ".COUT"}, 32'(bus.COUT), 32'(e.cout));
`ifdef ULA_ZERO_FLAG_EN
        check({tag, ".Z"}, 32'(bus.Z), 32'(e.z));
`endif
    endtask

    // Compare the previous result, glitch the inputs, confirm the outputs hold,
    // then settle on the real operands for the next edge.
    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [2:0] x);
        exp_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'(0), 32'(1));
            e = '0;
        end else begin
            e = sb_q.pop_front();
            check_outputs({tag, ".prev"}, e);
        end
        bus.A   = 8'($urandom);
        bus.B   = 8'($urandom);
        bus.CIN = 1'($urandom);
        bus.X   = 3'($urandom);
        #2;
        check_outputs({tag, ".hold"}, e);
        bus.A   = a;
        bus.B   = b;
        bus.CIN = cin;
        bus.X   = x;
        sb_q.push_back(model(a, b, cin, x));
    endtask

    task automatic mid_reset();
        exp_t zero_e;
        zero_e = '{s: 8'h00, cout: 1'b0, z: 1'b1};
        @(negedge clk);
        if (sb_q.size() != 0) check_outputs("mid_rst.prev", sb_q.pop_front());
        bus.A   = 8'h12;
        bus.B   = 8'h34;
        bus.CIN = 1'b0;
        bus.X   = 3'b000;
        #2 rst = 1'b1;
        #1 check_outputs("mid_rst.async", zero_e);
        @(posedge clk);
        #1 check_outputs("mid_rst.held", zero_e);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(model(bus.A, bus.B, bus.CIN, bus.X));
    endtask

    initial begin
        rst     = 1'b1;
        bus.A   = 8'hFF;
        bus.B   = 8'hFF;
        bus.CIN = 1'b0;
        bus.X   = 3'b000;
        #2 check_outputs("reset", '{s: 8'h00, cout: 1'b0, z: 1'b1});
        #1 rst = 1'b0;
        sb_q.push_back('{s: 8'hFE, cout: 1'b1, z: 1'b0});

        step("add0", 8'b10000011, 8'b00000001, 1'b0, 3'b000);
        step("add1", 8'b00010011, 8'b00010001, 1'b0, 3'b000);
        step("add2", 8'hFF,       8'h00,       1'b1, 3'b000);
        step("addw", 8'hFF,       8'h01,       1'b0, 3'b000);
        step("sub0", 8'b10000011, 8'b00000001, 1'b0, 3'b001);
        step("sub1", 8'b10010010, 8'b00000110, 1'b0, 3'b001);
        step("sub2", 8'h00,       8'h01,       1'b0, 3'b001);
        step("subc", 8'h10,       8'h10,       1'b1, 3'b001);
        step("and",  8'b10000011, 8'b00000001, 1'b0, 3'b010);
        step("or",   8'b10000011, 8'b00000001, 1'b0, 3'b011);
        step("not",  8'b10000011, 8'b00000001, 1'b0, 3'b100);
        step("rsv5", 8'hA5,       8'h3C,       1'b1, 3'b101);
        step("rsv6", 8'hFF,       8'hFF,       1'b1, 3'b110);
        step("rsv7", 8'h7E,       8'h81,       1'b0, 3'b111);
        step("zsub", 8'h5A,       8'h5A,       1'b0, 3'b001);
        step("zor",  8'h01,       8'h00,       1'b0, 3'b011);
        mid_reset();
        for (int i = 0; i < 24; i++)
            step("rand", 8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));

        @(negedge clk);
        if (sb_q.size() != 0) check_outputs("drain", sb_q.pop_front());
        else                  check("drain.sb_empty", 32'(0), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_8_bits.md
Name: ula_8_bits

Overview:
8-bit arithmetic/logic unit with registered outputs. Built from a ripple chain of 1-bit full-adder/full-subtractor cells plus bitwise AND/OR/NOT logic. A 3-bit opcode selects the operation. The result and carry/borrow are captured on the clock edge. Sits in the datapath as the integer execution unit of the 8-bit processor.

Parameters:
WIDTH, 8, operand/result width; only 8 is required to be supported; the ripple chain is generated per bit.

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset; clears output registers immediately
CIN  input  1  carry-in for ADD, borrow-in for SUB; ignored by logic ops
A  input  8  operand A (bit 7 = MSB)
B  input  8  operand B; ignored by NOT
X  input  3  operation select
S  output  8  registered result
COUT  output  1  registered carry-out (ADD) or borrow-out (SUB); 0 for logic ops

Behaviour:
- Reset: while RST=1, S=8'h00 and COUT=0, asynchronously and independent of CLK. The first capture occurs on the first rising CLK edge after RST falls.
- Latency: 1 cycle. On each rising CLK edge with RST=0, S and COUT load the combinational result of the current A, B, CIN and X. There is no enable and no handshake; a new operation can start every cycle.
- Opcodes:
  - X=000 ADD: {COUT,S} = A + B + CIN, unsigned, 9-bit result. Bit 0 uses CIN; bit i+1 takes its carry from bit i.
  - X=001 SUB: S = (A - B - CIN) mod 256. COUT = 1 when A < B + CIN (borrow out of bit 7). Implemented as a ripple full-subtractor chain; CIN is the borrow into bit 0.
  - X=010 AND: S = A & B, COUT = 0.
  - X=011 OR: S = A | B, COUT = 0.
  - X=100 NOT: S = ~A, COUT = 0; B and CIN are don't-care.
  - X=101, 110, 111: reserved. S = 8'h00, COUT = 0.
- Wrap-around:
  - ADD 8'hFF + 8'h01 -> S=8'h00, COUT=1.
  - SUB 8'h00 - 8'h01 -> S=8'hFF, COUT=1.
- Reset mid-operation: the in-flight result is discarded and outputs go to zero. No other state exists.
- Inputs are sampled only at the clock edge. Combinational glitches on A/B/X between edges do not reach S/COUT.
- No X/Z propagation requirements beyond standard 4-state simulation. Inputs are assumed driven at the sampling edge.

Optional Feature:
- Macro ULA_ZERO_FLAG_EN.
- When defined: an extra output port Z (1 bit) is added. Z is registered alongside S, equals 1 when the next-state S is 8'h00, and resets to 1 with RST (since S resets to zero).
- When undefined: port Z does not exist and behaviour is otherwise identical.

Test Plan:
- Reset: assert RST=1 with A=8'hFF, B=8'hFF, X=000 -> S=8'h00, COUT=0 without any clock edge. Release RST; on the next edge -> S=8'hFE, COUT=1.
- ADD: CIN=0, X=000, A=8'b10000011, B=8'b00000001 -> S=8'b10000100, COUT=0. Then A=8'b00010011, B=8'b00010001 -> S=8'b00100100. Then A=8'hFF, B=8'h00, CIN=1 -> S=8'h00, COUT=1.
- SUB: CIN=0, X=001, A=8'b10000011, B=8'b00000001 -> S=8'b10000010, COUT=0. Then A=8'b10010010, B=8'b00000110 -> S=8'b10001100 (borrow ripples across the nibble boundary). Then A=8'h00, B=8'h01 -> S=8'hFF, COUT=1.
- Logic ops: A=8'b10000011, B=8'b00000001, CIN=0.
  - X=010 -> S=8'b00000001, COUT=0.
  - X=011 -> S=8'b10000011.
  - X=100 -> S=8'b01111100, COUT=0.
- Reserved opcodes and latency: X=101/110/111 with any operands -> S=8'h00, COUT=0. Change the operands between edges and check that S changes only at the rising CLK edge, exactly one cycle after the inputs are applied.
- With ULA_ZERO_FLAG_EN defined: X=001, A=B=8'h5A -> S=8'h00, Z=1. X=011, A=8'h01 -> Z=0.
